// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the regfile write port, merging pipeline writebacks with
// buffered long-latency results and tracking their pending destinations.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wd,
  output logic            lu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     busy_vec,
  output logic            stall_pipe
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]      fifo_rd_q [DEPTH];
  logic [XLEN-1:0] fifo_wd_q [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     busy_q, busy_d, set_vec, clr_vec;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            empty, pipe_sel, fifo_sel, byp_sel, push;
  always_comb begin
    empty       = count_q == '0;
    lu_ready    = count_q != (AW+1)'(DEPTH);
    pipe_sel    = !stall_q && pipe_we && pipe_rd != '0;
    fifo_sel    = !pipe_sel && !empty;
    byp_sel     = !pipe_sel && empty && lu_valid && lu_rd != '0;
    push        = lu_valid && lu_ready && !byp_sel && lu_rd != '0;
    rf_we       = rst_n && (pipe_sel || fifo_sel || byp_sel);
    rf_a3       = pipe_sel ? pipe_rd : fifo_sel ? fifo_rd_q[head_q] : lu_rd;
    rf_wd       = pipe_sel ? pipe_wd : fifo_sel ? fifo_wd_q[head_q] : lu_wd;
    issue_ready = !busy_q[issue_rd];
    set_vec     = (issue_valid && issue_ready) ? 32'(1) << issue_rd : '0;
    clr_vec     = (fifo_sel || byp_sel) ? 32'(1) << rf_a3 : '0;
    busy_d      = (busy_q | set_vec) & ~clr_vec & ~32'(1);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(fifo_sel);
    // Starvation is only counted against a waiting, unpopped FIFO head.
    stall_d     = !fifo_sel && !empty && starve_q == SW'(STARVE_MAX - 1);
    starve_d    = (fifo_sel || empty || stall_d) ? '0 : starve_q + SW'(1);
    busy_vec    = busy_q;
    stall_pipe  = stall_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q] <= lu_rd;
      fifo_wd_q[tail_q] <= lu_wd;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      head_q   <= head_q + AW'(fifo_sel);
      tail_q   <= tail_q + AW'(push);
      count_q  <= count_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized legal traffic, checked every
// cycle against a queue-based behavioural model of the write-port rules.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 8;
  typedef struct packed { logic [4:0] rd; logic [31:0] wd; } ent_t;
  logic clk, rst_n, issue_valid, issue_ready, pipe_we, lu_valid, lu_ready, rf_we, stall_pipe;
  logic [4:0] issue_rd, pipe_rd, lu_rd, rf_a3;
  logic [31:0] pipe_wd, lu_wd, rf_wd, busy_vec;
  int vectors = 0, miscompares = 0;
  ent_t q[$];
  logic [4:0] outst[$];
  logic [31:0] m_busy;
  int m_starve;
  logic m_stall, last_acc;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy_vec(busy_vec), .stall_pipe(stall_pipe));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    outst.delete();
    m_busy = '0;
    m_starve = 0;
    m_stall = 1'b0;
    last_acc = 1'b1;
  endtask

  task automatic zero_inputs();
    issue_valid = 0; issue_rd = 0; pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    lu_valid = 0; lu_rd = 0; lu_wd = 0;
  endtask

  // Compare this cycle against the model, then advance the model across the clock edge.
  task automatic step();
    logic exp_we, pop, byp, acc, iss_acc, nonempty;
    logic [4:0] exp_a3;
    logic [31:0] exp_wd;
    #1;
    pop = 0; byp = 0; exp_we = 1; exp_a3 = 0; exp_wd = 0;
    if (!m_stall && pipe_we && pipe_rd != 0) begin exp_a3 = pipe_rd; exp_wd = pipe_wd; end
    else if (q.size() > 0) begin exp_a3 = q[0].rd; exp_wd = q[0].wd; pop = 1; end
    else if (lu_valid && lu_rd != 0) begin exp_a3 = lu_rd; exp_wd = lu_wd; byp = 1; end
    else exp_we = 0;
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      chk("rf_a3", 32'(rf_a3), 32'(exp_a3));
      chk("rf_wd", rf_wd, exp_wd);
    end
    chk("lu_ready", 32'(lu_ready), 32'(q.size() < DEPTH));
    chk("issue_ready", 32'(issue_ready), 32'(!m_busy[issue_rd]));
    chk("busy_vec", busy_vec, m_busy);
    chk("stall_pipe", 32'(stall_pipe), 32'(m_stall));
    acc = lu_valid && q.size() < DEPTH;
    iss_acc = issue_valid && !m_busy[issue_rd] && issue_rd != 0;
    nonempty = q.size() > 0;
    last_acc = acc;
    if (pop) begin m_busy[q[0].rd] = 1'b0; void'(q.pop_front()); end
    if (byp) m_busy[lu_rd] = 1'b0;
    if (acc && !byp && lu_rd != 0) q.push_back('{rd: lu_rd, wd: lu_wd});
    if (iss_acc) begin m_busy[issue_rd] = 1'b1; outst.push_back(issue_rd); end
    m_stall = 1'b0;
    if (pop) m_starve = 0;
    else if (nonempty) begin
      m_starve++;
      if (m_starve == STARVE_MAX) begin m_starve = 0; m_stall = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
    step();
    issue_valid = 0;
  endtask

  initial begin
    zero_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    // x0 everywhere
    issue_valid = 1; issue_rd = 0; lu_valid = 1; lu_rd = 0; lu_wd = 32'h1234;
    pipe_we = 1; pipe_rd = 0; pipe_wd = 32'h5678;
    #1;
    chk("x0_issue_ready", 32'(issue_ready), 1);
    chk("x0_lu_ready", 32'(lu_ready), 1);
    chk("x0_rf_we", 32'(rf_we), 0);
    step();
    chk("x0_busy", busy_vec, 0);
    zero_inputs();
    // bypass with idle pipe and empty FIFO
    issue(5);
    chk("busy5_set", 32'(busy_vec[5]), 1);
    lu_valid = 1; lu_rd = 5; lu_wd = 32'hDEADBEEF;
    #1;
    chk("byp_we", 32'(rf_we), 1);
    chk("byp_a3", 32'(rf_a3), 5);
    chk("byp_wd", rf_wd, 32'hDEADBEEF);
    step();
    lu_valid = 0;
    chk("busy5_clr", 32'(busy_vec[5]), 0);
    // pipe beats lu; queued results drain in order
    issue(7); issue(9); issue(10);
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h33; lu_valid = 1; lu_rd = 7; lu_wd = 32'h77;
    #1;
    chk("ord_a3_3", 32'(rf_a3), 3);
    step();
    pipe_we = 0; lu_rd = 9; lu_wd = 32'h99;
    #1;
    chk("ord_a3_7", 32'(rf_a3), 7);
    step();
    lu_rd = 10; lu_wd = 32'hAA;
    #1;
    chk("ord_a3_9", 32'(rf_a3), 9);
    step();
    lu_valid = 0;
    #1;
    chk("ord_a3_10", 32'(rf_a3), 10);
    step();
    #1;
    chk("ord_empty_we", 32'(rf_we), 0);
    step();
    // full FIFO under continuous pipe traffic, then starvation stall
    pipe_we = 1; pipe_rd = 1;
    for (int i = 0; i < 5; i++) begin pipe_wd = $urandom; issue(5'(11 + i)); end
    for (int k = 0; k <= 10; k++) begin
      pipe_wd = $urandom;
      lu_valid = 1;
      if (k < 4) begin lu_rd = 5'(11 + k); lu_wd = 32'h100 + k; end
      else if (k == 4) begin lu_rd = 15; lu_wd = 32'h1F5; end
      #1;
      chk("full_lu_ready", 32'(lu_ready), 32'(k < 4 || k == 10));
      chk("starve_stall", 32'(stall_pipe), 32'(k == 9));
      chk("held_lu_rd", 32'(lu_rd), 32'(k < 4 ? 11 + k : 15));
      if (k == 9) chk("stall_head", 32'(rf_a3), 11);
      step();
    end
    zero_inputs();
    repeat (6) step();
    chk("drained_busy", busy_vec, 0);
    // reset mid-stream with entries queued and x5..x7 busy
    issue(5); issue(6); issue(7);
    pipe_we = 1; pipe_rd = 2;
    for (int i = 0; i < 3; i++) begin
      pipe_wd = $urandom; lu_valid = 1; lu_rd = 5'(5 + i); lu_wd = $urandom;
      step();
    end
    lu_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_lu_ready", 32'(lu_ready), 1);
    chk("rst_stall", 32'(stall_pipe), 0);
    model_reset();
    zero_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    // randomized legal traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(lu_valid && !last_acc)) begin
        int r;
        r = $urandom_range(99);
        lu_valid = 0;
        if (r < 5) begin lu_valid = 1; lu_rd = 0; lu_wd = $urandom; end
        else if (r < 45 && outst.size() > 0) begin
          int k;
          k = $urandom_range(outst.size() - 1);
          lu_valid = 1; lu_rd = outst[k]; lu_wd = $urandom;
          outst.delete(k);
        end
      end
      if (!m_stall) begin
        pipe_we = $urandom_range(99) < 60;
        pipe_rd = 5'($urandom);
        for (int t = 0; t < 8 && m_busy[pipe_rd]; t++) pipe_rd = 5'($urandom);
        if (m_busy[pipe_rd]) pipe_we = 0;
        pipe_wd = $urandom;
      end
      issue_valid = $urandom_range(99) < 30;
      issue_rd = 5'($urandom);
      if (pipe_we && issue_rd == pipe_rd) issue_valid = 0;
      step();
    end
    zero_inputs();
    while (outst.size() > 0) begin
      lu_valid = 1; lu_rd = outst[0]; lu_wd = $urandom;
      void'(outst.pop_front());
      for (int t = 0; t < 20 && !last_acc; t++) step();
      step();
      while (!last_acc) step();
    end
    lu_valid = 0;
    repeat (8) step();
    chk("final_busy", busy_vec, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
